// File: rtl/vga_rect_filler.sv
// Rectangle-fill drawing engine feeding the 160x120 back buffer.
// Emits one pixel write per cycle, then handshakes the buffer swap.
module vga_rect_filler #(
  parameter int FB_WIDTH  = 160,
  parameter int FB_HEIGHT = 120,
  parameter int ADDR_W    = 15,
  parameter int COLOR_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [7:0]         cmd_x,
  input  logic [6:0]         cmd_y,
  input  logic [7:0]         cmd_w,
  input  logic [6:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_last,
  output logic               vga_write_en,
  output logic [ADDR_W-1:0]  vga_write_address,
  output logic [COLOR_W-1:0] vga_data,
  output logic               write_done,
  input  logic               swap_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE,
    WAIT_SWAP
  } state_t;

  localparam logic [8:0]        W9  = 9'(FB_WIDTH);
  localparam logic [7:0]        H8  = 8'(FB_HEIGHT);
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(FB_WIDTH);

  state_t state, state_d;

  logic [7:0]        x_start;
  logic [7:0]        x_end;
  logic [6:0]        y_end;
  logic [7:0]        x_cur;
  logic [6:0]        y_cur;
  logic [ADDR_W-1:0] row_base;
  logic              last_r;

  logic [8:0]        x_sum;
  logic [7:0]        y_sum;
  logic [7:0]        x_clip;
  logic [6:0]        y_clip;
  logic              empty;
  logic              accept;
  logic              load;
  logic              col_end;
  logic              row_end;
  logic              px_last;
  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] y_base;

  assign x_sum  = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum  = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign x_clip = (x_sum > W9) ? W9[7:0] : x_sum[7:0];
  assign y_clip = (y_sum > H8) ? H8[6:0] : y_sum[6:0];
  assign empty  = (cmd_w == 8'd0) || (cmd_h == 7'd0) ||
                  ({1'b0, cmd_x} >= W9) || ({1'b0, cmd_y} >= H8);

  assign col_end = ((x_cur + 8'd1) == x_end);
  assign row_end = ((y_cur + 7'd1) == y_end);
  assign px_last = col_end && row_end;

  // The final write of a non-last command overlaps the next acceptance.
  assign cmd_ready = (state == IDLE) ||
                     ((state == FILL) && px_last && !last_r);
  assign busy      = (state != IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign load      = accept && !empty;

  // Constant shift-add of the row stride, evaluated only at acceptance.
  assign y_ext = ADDR_W'(cmd_y);
  always_comb begin
    y_base = '0;
    for (int i = 0; i < 9; i++) begin
      if (W9[i]) y_base = y_base + (y_ext << i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!empty)        state_d = FILL;
          else if (cmd_last) state_d = DONE;
        end
      end
      FILL: begin
        if (px_last) begin
          if (last_r)        state_d = DONE;
          else if (load)     state_d = FILL;
          else if (accept)   state_d = cmd_last ? DONE : IDLE;
          else               state_d = IDLE;
        end
      end
      DONE:      state_d = WAIT_SWAP;
      WAIT_SWAP: if (swap_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_write_en      <= 1'b0;
      vga_write_address <= '0;
      vga_data          <= '0;
      write_done        <= 1'b0;
      x_start           <= '0;
      x_end             <= '0;
      y_end             <= '0;
      x_cur             <= '0;
      y_cur             <= '0;
      row_base          <= '0;
      last_r            <= 1'b0;
    end else begin
      vga_write_en <= (state_d == FILL);
      write_done   <= (state_d == DONE);
      if (load) begin
        x_start           <= cmd_x;
        x_end             <= x_clip;
        y_end             <= y_clip;
        x_cur             <= cmd_x;
        y_cur             <= cmd_y;
        row_base          <= y_base;
        vga_write_address <= y_base + ADDR_W'(cmd_x);
        vga_data          <= cmd_color;
        last_r            <= cmd_last;
      end else if ((state == FILL) && !px_last) begin
        if (col_end) begin
          x_cur             <= x_start;
          y_cur             <= y_cur + 7'd1;
          row_base          <= row_base + ROW;
          vga_write_address <= row_base + ROW + ADDR_W'(x_start);
        end else begin
          x_cur             <= x_cur + 8'd1;
          vga_write_address <= vga_write_address + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Directed bench for vga_rect_filler with a pixel-write scoreboard.
// Expected writes are queued at command time and popped per write.
module tb_vga_rect_filler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [23:0] cmd_color;
  logic        cmd_last;
  logic        vga_write_en;
  logic [14:0] vga_write_address;
  logic [23:0] vga_data;
  logic        write_done;
  logic        swap_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt  = 0;
  int done_cnt = 0;
  int max_addr = 0;
  logic [38:0] sb[$];

  vga_rect_filler dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_x             (cmd_x),
    .cmd_y             (cmd_y),
    .cmd_w             (cmd_w),
    .cmd_h             (cmd_h),
    .cmd_color         (cmd_color),
    .cmd_last          (cmd_last),
    .vga_write_en      (vga_write_en),
    .vga_write_address (vga_write_address),
    .vga_data          (vga_data),
    .write_done        (write_done),
    .swap_done         (swap_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (write_done) done_cnt++;
      if (vga_write_en) begin
        logic [38:0] e;
        wr_cnt++;
        if (int'(vga_write_address) > max_addr)
          max_addr = int'(vga_write_address);
        check("write_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("wr_addr", 32'(vga_write_address), 32'(e[38:24]));
          check("wr_data", 32'(vga_data), 32'(e[23:0]));
        end
      end
    end
  end

  task automatic push_model(input int x, input int y, input int w,
                            input int h, input logic [23:0] c);
    int xe, ye;
    xe = (x + w > 160) ? 160 : x + w;
    ye = (y + h > 120) ? 120 : y + h;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++)
        sb.push_back({15'(yy * 160 + xx), c});
  endtask

  task automatic send(input int x, input int y, input int w, input int h,
                      input logic [23:0] c, input logic l);
    int n;
    push_model(x, y, w, h, c);
    @(negedge clk);
    cmd_x     = 8'(x);
    cmd_y     = 7'(y);
    cmd_w     = 8'(w);
    cmd_h     = 7'(h);
    cmd_color = c;
    cmd_last  = l;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(cmd_ready && !busy && !vga_write_en) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(cmd_ready && !busy), 1);
  endtask

  task automatic pulse_swap();
    @(negedge clk);
    swap_done = 1'b1;
    @(negedge clk);
    swap_done = 1'b0;
  endtask

  initial begin
    int w0, d0, n;
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    cmd_color = '0; cmd_last = 1'b0; swap_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_wen", 32'(vga_write_en), 0);
    check("rst_done", 32'(write_done), 0);
    check("rst_addr", 32'(vga_write_address), 0);
    check("rst_data", 32'(vga_data), 0);
    rst = 1'b1;

    // 2x2 at origin
    w0 = wr_cnt; d0 = done_cnt;
    send(0, 0, 2, 2, 24'hFF0000, 1'b0);
    wait_idle(50);
    check("t1_writes", 32'(wr_cnt - w0), 4);
    check("t1_no_done", 32'(done_cnt - d0), 0);
    check("t1_sb_empty", 32'(sb.size()), 0);

    // clipped corner
    w0 = wr_cnt;
    send(158, 118, 5, 5, 24'h00FF00, 1'b0);
    wait_idle(50);
    check("t2_writes", 32'(wr_cnt - w0), 4);
    check("t2_max_addr", 32'(max_addr), 19199);
    check("t2_sb_empty", 32'(sb.size()), 0);

    // empty last command
    w0 = wr_cnt;
    send(0, 0, 0, 1, 24'h123456, 1'b1);
    @(negedge clk);
    check("t3_done_pulse", 32'(write_done), 1);
    check("t3_no_wen", 32'(vga_write_en), 0);
    check("t3_not_ready", 32'(cmd_ready), 0);
    @(negedge clk);
    check("t3_done_low", 32'(write_done), 0);
    repeat (3) @(negedge clk);
    check("t3_wait_ready", 32'(cmd_ready), 0);
    check("t3_wait_busy", 32'(busy), 1);
    check("t3_writes", 32'(wr_cnt - w0), 0);
    pulse_swap();
    check("t3_ready_after", 32'(cmd_ready), 1);
    check("t3_busy_after", 32'(busy), 0);

    // back-to-back 1x1 commands, valid held
    w0 = wr_cnt;
    push_model(5, 5, 1, 1, 24'h0000AA);
    @(negedge clk);
    cmd_x = 8'd5; cmd_y = 7'd5; cmd_w = 8'd1; cmd_h = 7'd1;
    cmd_color = 24'h0000AA; cmd_last = 1'b0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    push_model(6, 6, 1, 1, 24'h0000BB);
    cmd_x = 8'd6; cmd_y = 7'd6; cmd_color = 24'h0000BB;
    @(negedge clk);
    check("t4_wen1", 32'(vga_write_en), 1);
    check("t4_ready_last", 32'(cmd_ready), 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("t4_wen2", 32'(vga_write_en), 1);
    check("t4_addr2", 32'(vga_write_address), 966);
    @(negedge clk);
    check("t4_wen_off", 32'(vga_write_en), 0);
    check("t4_hold_addr", 32'(vga_write_address), 966);
    check("t4_writes", 32'(wr_cnt - w0), 2);

    // full-screen fill with early swap_done ignored
    w0 = wr_cnt; d0 = done_cnt;
    send(0, 0, 160, 120, 24'h0F0F0F, 1'b1);
    n = 0;
    while (!write_done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("t5_done_seen", 32'(write_done), 1);
    swap_done = 1'b1;
    @(negedge clk);
    swap_done = 1'b0;
    check("t5_writes", 32'(wr_cnt - w0), 19200);
    check("t5_done_cnt", 32'(done_cnt - d0), 1);
    check("t5_sb_empty", 32'(sb.size()), 0);
    check("t5_early_swap", 32'(cmd_ready), 0);
    check("t5_busy", 32'(busy), 1);
    pulse_swap();
    check("t5_ready", 32'(cmd_ready), 1);
    check("t5_max_addr", 32'(max_addr), 19199);

    // reset mid-fill
    send(20, 20, 10, 10, 24'hABCDEF, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_wen_rst", 32'(vga_write_en), 0);
    check("t6_busy_rst", 32'(busy), 0);
    check("t6_ready_rst", 32'(cmd_ready), 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    w0 = wr_cnt;
    repeat (20) @(negedge clk);
    check("t6_no_resid", 32'(wr_cnt - w0), 0);
    check("t6_ready_after", 32'(cmd_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
